// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: {rd,sel} register addresses, Status/Cause bit positions,
// software write masks, reset values and the exception code enumeration.
package cp0_pkg;
   localparam logic [7:0] CP0_INDEX    = {5'd0,  3'd0};
   localparam logic [7:0] CP0_RANDOM   = {5'd1,  3'd0};
   localparam logic [7:0] CP0_ENTRYLO0 = {5'd2,  3'd0};
   localparam logic [7:0] CP0_ENTRYLO1 = {5'd3,  3'd0};
   localparam logic [7:0] CP0_CONTEXT  = {5'd4,  3'd0};
   localparam logic [7:0] CP0_WIRED    = {5'd6,  3'd0};
   localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] CP0_ENTRYHI  = {5'd10, 3'd0};
   localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};
   localparam logic [7:0] CP0_PRID     = {5'd15, 3'd0};
   localparam logic [7:0] CP0_CONFIG   = {5'd16, 3'd0};
   localparam logic [7:0] CP0_CONFIG1  = {5'd16, 3'd1};

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_BEV = 22;
   localparam int CA_TI  = 30;
   localparam int CA_BD  = 31;

   localparam logic [31:0] STATUS_RST = 32'h0040_0000;
   localparam logic [31:0] CONFIG_RST = 32'h8000_0003;
   localparam logic [2:0]  K0_RST     = 3'd3;
   localparam logic [31:0] ST_WMASK   = 32'h0000_FF03;
   localparam logic [31:0] LO_WMASK   = 32'h03FF_FFFF;
   localparam logic [31:0] HI_WMASK   = 32'hFFFF_E0FF;

   typedef enum logic [4:0] {
      EXC_INT  = 5'h00,
      EXC_MOD  = 5'h01,
      EXC_TLBL = 5'h02,
      EXC_TLBS = 5'h03,
      EXC_ADEL = 5'h04,
      EXC_ADES = 5'h05,
      EXC_SYS  = 5'h08,
      EXC_BP   = 5'h09,
      EXC_RI   = 5'h0A,
      EXC_OV   = 5'h0C
   } exc_code_e;
endpackage

// File: rtl/cp0_tlb_timer_if.sv
// CP0 bus: slave is the register file, master is the pipeline (execute + commit).
// Reads are combinational; all updates land on the next clock edge.
interface cp0_tlb_timer_if #(parameter int TLB_ENTRIES = 16);
   localparam int IDX_W = $clog2(TLB_ENTRIES);

   logic [5:0]       interrupt;
   logic [7:0]       r_addr;
   logic [31:0]      r_data;
   logic             w_ena;
   logic [7:0]       w_addr;
   logic [31:0]      w_data;
   logic             exc_valid;
   logic [4:0]       exc_code;
   logic             exc_bd;
   logic [31:0]      exc_epc;
   logic             exc_badvaddr_ena;
   logic [31:0]      exc_badvaddr;
   logic             exc_entryhi_ena;
   logic             eret;
   logic             tlbp_ena;
   logic             tlbp_hit;
   logic [IDX_W-1:0] tlbp_idx;
   logic             tlbr_ena;
   logic [31:0]      tlbr_entryhi;
   logic [31:0]      tlbr_entrylo0;
   logic [31:0]      tlbr_entrylo1;
   logic [31:0]      epc;
   logic [31:0]      status;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] random;
   logic [31:0]      entryhi;
   logic [31:0]      entrylo0;
   logic [31:0]      entrylo1;
   logic [2:0]       config_k0;
   logic             has_int;

   modport master (
      output interrupt, r_addr, w_ena, w_addr, w_data,
      output exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_ena, exc_badvaddr, exc_entryhi_ena,
      output eret, tlbp_ena, tlbp_hit, tlbp_idx, tlbr_ena, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
      input  r_data, epc, status, index, random, entryhi, entrylo0, entrylo1, config_k0, has_int
   );

   modport slave (
      input  interrupt, r_addr, w_ena, w_addr, w_data,
      input  exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_ena, exc_badvaddr, exc_entryhi_ena,
      input  eret, tlbp_ena, tlbp_hit, tlbp_idx, tlbr_ena, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
      output r_data, epc, status, index, random, entryhi, entrylo0, entrylo1, config_k0, has_int
   );
endinterface

// File: rtl/cp0_random_gen.sv
// TLBWR Random index: counts down from TLB_ENTRIES-1 to Wired (or 0), then reloads.
// One-cycle update; a Wired write reloads the top value on that same edge.
module cp0_random_gen #(
   parameter int TLB_ENTRIES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [$clog2(TLB_ENTRIES)-1:0] i_wired,
   input  logic                           i_wired_wr,
   output logic [$clog2(TLB_ENTRIES)-1:0] o_random
);
   localparam int IDX_W = $clog2(TLB_ENTRIES);
   localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

   logic [IDX_W-1:0] r_random;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_random <= TOP;
      end else if (i_wired_wr || r_random == i_wired || r_random == '0) begin
         r_random <= TOP;
      end else begin
         r_random <= r_random - IDX_W'(1);
      end
   end

   assign o_random = r_random;
endmodule

// File: rtl/cp0_tlb_timer.sv
// CP0 system-control register file with TLB support registers, prescaled Count/Compare timer
// and interrupt gating; reads are combinational, every update takes effect on the next edge.
module cp0_tlb_timer
   import cp0_pkg::*;
#(
   parameter int          TLB_ENTRIES = 16,
   parameter int          COUNT_DIV   = 2,
   parameter logic [31:0] PRID        = 32'h0000_4220
) (
   input  logic           clk,
   input  logic           rst,
   cp0_tlb_timer_if.slave bus
);
   localparam int IDX_W = $clog2(TLB_ENTRIES);
   localparam int PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);

   logic             r_index_p;
   logic [IDX_W-1:0] r_index_lo, r_wired;
   logic [31:0]      r_entrylo0, r_entrylo1, r_entryhi, r_context, r_badvaddr;
   logic [31:0]      r_count, r_compare, r_status, r_cause, r_epc;
   logic [2:0]       r_k0;
   logic [PRE_W-1:0] r_pre;

   logic             w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_ctx, w_wr_wired, w_wr_count;
   logic             w_wr_hi, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_wr_config;
   logic             w_tick, w_inc, w_exl;
   logic [18:0]      w_vpn2;
   logic [IDX_W-1:0] w_random;
   logic [31:0]      w_rdata;

   assign w_wr_index   = bus.w_ena && (bus.w_addr == CP0_INDEX);
   assign w_wr_lo0     = bus.w_ena && (bus.w_addr == CP0_ENTRYLO0);
   assign w_wr_lo1     = bus.w_ena && (bus.w_addr == CP0_ENTRYLO1);
   assign w_wr_ctx     = bus.w_ena && (bus.w_addr == CP0_CONTEXT);
   assign w_wr_wired   = bus.w_ena && (bus.w_addr == CP0_WIRED);
   assign w_wr_count   = bus.w_ena && (bus.w_addr == CP0_COUNT);
   assign w_wr_hi      = bus.w_ena && (bus.w_addr == CP0_ENTRYHI);
   assign w_wr_compare = bus.w_ena && (bus.w_addr == CP0_COMPARE);
   assign w_wr_status  = bus.w_ena && (bus.w_addr == CP0_STATUS);
   assign w_wr_cause   = bus.w_ena && (bus.w_addr == CP0_CAUSE);
   assign w_wr_epc     = bus.w_ena && (bus.w_addr == CP0_EPC);
   assign w_wr_config  = bus.w_ena && (bus.w_addr == CP0_CONFIG);

   // A software Count load replaces the increment, so it cannot also raise TI.
   assign w_tick = (r_pre == PRE_MAX);
   assign w_inc  = w_tick && !w_wr_count;
   assign w_exl  = r_status[ST_EXL];
   assign w_vpn2 = bus.exc_badvaddr[31:13];

   cp0_random_gen #(.TLB_ENTRIES(TLB_ENTRIES)) u_random (
      .clk        (clk),
      .rst        (rst),
      .i_wired    (r_wired),
      .i_wired_wr (w_wr_wired),
      .o_random   (w_random)
   );

   // Later assignments override earlier ones: free-run < software < TLB < ERET < exception.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_index_p  <= 1'b0;
         r_index_lo <= '0;
         r_wired    <= '0;
         r_entrylo0 <= '0;
         r_entrylo1 <= '0;
         r_entryhi  <= '0;
         r_context  <= '0;
         r_badvaddr <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_pre      <= '0;
         r_status   <= STATUS_RST;
         r_cause    <= '0;
         r_epc      <= '0;
         r_k0       <= K0_RST;
      end else begin
         r_cause[15:10] <= {bus.interrupt[5] | r_cause[CA_TI], bus.interrupt[4:0]};
         if (w_inc && (r_count == r_compare)) r_cause[CA_TI] <= 1'b1;
         if (w_wr_compare) r_cause[CA_TI] <= 1'b0;

         if (w_wr_count) begin
            r_count <= bus.w_data;
            r_pre   <= '0;
         end else begin
            r_count <= r_count + {31'b0, w_inc};
            r_pre   <= w_tick ? '0 : r_pre + PRE_W'(1);
         end

         if (w_wr_index)   r_index_lo     <= bus.w_data[IDX_W-1:0];
         if (w_wr_wired)   r_wired        <= bus.w_data[IDX_W-1:0];
         if (w_wr_lo0)     r_entrylo0     <= bus.w_data & LO_WMASK;
         if (w_wr_lo1)     r_entrylo1     <= bus.w_data & LO_WMASK;
         if (w_wr_hi)      r_entryhi      <= bus.w_data & HI_WMASK;
         if (w_wr_ctx)     r_context[31:23] <= bus.w_data[31:23];
         if (w_wr_compare) r_compare      <= bus.w_data;
         if (w_wr_status)  r_status       <= (r_status & ~ST_WMASK) | (bus.w_data & ST_WMASK);
         if (w_wr_cause)   r_cause[9:8]   <= bus.w_data[9:8];
         if (w_wr_epc)     r_epc          <= bus.w_data;
         if (w_wr_config)  r_k0           <= bus.w_data[2:0];

         if (bus.tlbr_ena) begin
            r_entryhi  <= bus.tlbr_entryhi & HI_WMASK;
            r_entrylo0 <= bus.tlbr_entrylo0 & LO_WMASK;
            r_entrylo1 <= bus.tlbr_entrylo1 & LO_WMASK;
         end
         if (bus.tlbp_ena) begin
            if (bus.tlbp_hit) begin
               r_index_p  <= 1'b0;
               r_index_lo <= bus.tlbp_idx;
            end else begin
               r_index_p  <= 1'b1;
            end
         end

         if (bus.eret) r_status[ST_EXL] <= 1'b0;

         if (bus.exc_valid) begin
            r_status[ST_EXL] <= 1'b1;
            r_cause[6:2]     <= bus.exc_code;
            // Nested exceptions keep the original return point.
            if (!w_exl) begin
               r_cause[CA_BD] <= bus.exc_bd;
               r_epc          <= bus.exc_epc;
            end
            if (bus.exc_badvaddr_ena) begin
               r_badvaddr      <= bus.exc_badvaddr;
               r_context[22:4] <= w_vpn2;
            end
            if (bus.exc_entryhi_ena) r_entryhi[31:13] <= w_vpn2;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.r_addr)
         CP0_INDEX: begin
            w_rdata     = 32'(r_index_lo);
            w_rdata[31] = r_index_p;
         end
         CP0_RANDOM:   w_rdata = 32'(w_random);
         CP0_ENTRYLO0: w_rdata = r_entrylo0;
         CP0_ENTRYLO1: w_rdata = r_entrylo1;
         CP0_CONTEXT:  w_rdata = r_context;
         CP0_WIRED:    w_rdata = 32'(r_wired);
         CP0_BADVADDR: w_rdata = r_badvaddr;
         CP0_COUNT:    w_rdata = r_count;
         CP0_ENTRYHI:  w_rdata = r_entryhi;
         CP0_COMPARE:  w_rdata = r_compare;
         CP0_STATUS:   w_rdata = r_status;
         CP0_CAUSE:    w_rdata = r_cause;
         CP0_EPC:      w_rdata = r_epc;
         CP0_PRID:     w_rdata = PRID;
         CP0_CONFIG:   w_rdata = (CONFIG_RST & ~32'h7) | {29'b0, r_k0};
         default:      w_rdata = '0;
      endcase
   end

   assign bus.r_data    = w_rdata;
   assign bus.epc       = r_epc;
   assign bus.status    = r_status;
   assign bus.index     = r_index_lo;
   assign bus.random    = w_random;
   assign bus.entryhi   = r_entryhi;
   assign bus.entrylo0  = r_entrylo0;
   assign bus.entrylo1  = r_entrylo1;
   assign bus.config_k0 = r_k0;
   assign bus.has_int   = (|(r_cause[15:8] & r_status[15:8])) & r_status[ST_IE] & ~r_status[ST_EXL];
endmodule

// File: tb/tb_cp0_tlb_timer.sv
// Self-checking bench for cp0_tlb_timer: register-map vector tables plus hand sequences
// for the timer, Random, exception/ERET, TLBP/TLBR and reset corner cases.
module tb_cp0_tlb_timer;
   import cp0_pkg::*;

   localparam int TLB_ENTRIES = 16;

   logic clk;
   logic rst;

   cp0_tlb_timer_if #(.TLB_ENTRIES(TLB_ENTRIES)) bus ();

   cp0_tlb_timer #(
      .TLB_ENTRIES (TLB_ENTRIES),
      .COUNT_DIV   (2),
      .PRID        (32'h0000_4220)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      string       nm;
      bit          do_wr;
      logic [7:0]  waddr;
      logic [31:0] wdata;
      logic [7:0]  raddr;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      string       nm;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[$];
   sb_t  sbq[$];
   sb_t  mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // r_data is combinational: the expected value queued at drive time is checked mid-cycle.
   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         chk(mon_e.nm, bus.r_data, mon_e.exp);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.w_ena  = 1'b1;
      bus.w_addr = a;
      bus.w_data = d;
      tick();
      bus.w_ena  = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
      sb_t e;
      e.nm  = nm;
      e.exp = exp;
      bus.r_addr = a;
      sbq.push_back(e);
      tick();
   endtask

   task automatic add(input string nm, input bit do_wr, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [7:0] ra, input logic [31:0] exp);
      vec_t v;
      v.nm = nm; v.do_wr = do_wr; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic run_vecs();
      foreach (vecs[k]) begin
         if (vecs[k].do_wr) wr(vecs[k].waddr, vecs[k].wdata);
         rd(vecs[k].nm, vecs[k].raddr, vecs[k].exp);
      end
      vecs.delete();
   endtask

   task automatic set_exc(input logic [31:0] epc, input logic [4:0] code, input logic bd,
                          input logic bv_ena, input logic hi_ena, input logic [31:0] bva);
      bus.exc_valid        = 1'b1;
      bus.exc_epc          = epc;
      bus.exc_code         = code;
      bus.exc_bd           = bd;
      bus.exc_badvaddr_ena = bv_ena;
      bus.exc_entryhi_ena  = hi_ena;
      bus.exc_badvaddr     = bva;
   endtask

   initial begin
      rst = 1'b1;
      bus.interrupt = '0;  bus.r_addr = '0;  bus.w_ena = 1'b0; bus.w_addr = '0; bus.w_data = '0;
      bus.exc_valid = 1'b0; bus.exc_code = '0; bus.exc_bd = 1'b0; bus.exc_epc = '0;
      bus.exc_badvaddr_ena = 1'b0; bus.exc_badvaddr = '0; bus.exc_entryhi_ena = 1'b0;
      bus.eret = 1'b0; bus.tlbp_ena = 1'b0; bus.tlbp_hit = 1'b0; bus.tlbp_idx = '0;
      bus.tlbr_ena = 1'b0; bus.tlbr_entryhi = '0; bus.tlbr_entrylo0 = '0; bus.tlbr_entrylo1 = '0;
      tick();
      tick();

      // Reset values, read while reset is still held so free-running state stays put.
      chk("rst_has_int", 32'(bus.has_int), 32'h0);
      chk("rst_random_out", 32'(bus.random), 32'd15);
      chk("rst_k0", 32'(bus.config_k0), 32'd3);
      add("rst_status",   0, 8'h0, 32'h0, CP0_STATUS,   32'h0040_0000);
      add("rst_cause",    0, 8'h0, 32'h0, CP0_CAUSE,    32'h0000_0000);
      add("rst_count",    0, 8'h0, 32'h0, CP0_COUNT,    32'h0000_0000);
      add("rst_compare",  0, 8'h0, 32'h0, CP0_COMPARE,  32'h0000_0000);
      add("rst_index",    0, 8'h0, 32'h0, CP0_INDEX,    32'h0000_0000);
      add("rst_wired",    0, 8'h0, 32'h0, CP0_WIRED,    32'h0000_0000);
      add("rst_random",   0, 8'h0, 32'h0, CP0_RANDOM,   32'h0000_000F);
      add("rst_entryhi",  0, 8'h0, 32'h0, CP0_ENTRYHI,  32'h0000_0000);
      add("rst_entrylo0", 0, 8'h0, 32'h0, CP0_ENTRYLO0, 32'h0000_0000);
      add("rst_entrylo1", 0, 8'h0, 32'h0, CP0_ENTRYLO1, 32'h0000_0000);
      add("rst_context",  0, 8'h0, 32'h0, CP0_CONTEXT,  32'h0000_0000);
      add("rst_epc",      0, 8'h0, 32'h0, CP0_EPC,      32'h0000_0000);
      add("rst_badvaddr", 0, 8'h0, 32'h0, CP0_BADVADDR, 32'h0000_0000);
      add("rst_config",   0, 8'h0, 32'h0, CP0_CONFIG,   32'h8000_0003);
      add("rst_prid",     0, 8'h0, 32'h0, CP0_PRID,     32'h0000_4220);
      add("rst_unmapped", 0, 8'h0, 32'h0, {5'd5, 3'd0}, 32'h0000_0000);
      run_vecs();

      // Write masks: Compare first so the post-reset Count==Compare match never fires.
      rst = 1'b0;
      add("m_compare",  1, CP0_COMPARE,  32'hFFFF_0000, CP0_COMPARE,  32'hFFFF_0000);
      add("m_index",    1, CP0_INDEX,    32'hFFFF_FFFF, CP0_INDEX,    32'h0000_000F);
      add("m_entrylo0", 1, CP0_ENTRYLO0, 32'hFFFF_FFFF, CP0_ENTRYLO0, 32'h03FF_FFFF);
      add("m_entrylo1", 1, CP0_ENTRYLO1, 32'hA5A5_A5A5, CP0_ENTRYLO1, 32'h01A5_A5A5);
      add("m_context",  1, CP0_CONTEXT,  32'hFFFF_FFFF, CP0_CONTEXT,  32'hFF80_0000);
      add("m_entryhi",  1, CP0_ENTRYHI,  32'hFFFF_FFFF, CP0_ENTRYHI,  32'hFFFF_E0FF);
      add("m_status",   1, CP0_STATUS,   32'hFFFF_FFFC, CP0_STATUS,   32'h0040_FF00);
      add("m_cause",    1, CP0_CAUSE,    32'hFFFF_FFFF, CP0_CAUSE,    32'h0000_0300);
      add("m_config",   1, CP0_CONFIG,   32'hFFFF_FFFA, CP0_CONFIG,   32'h8000_0002);
      add("m_epc",      1, CP0_EPC,      32'h1234_5678, CP0_EPC,      32'h1234_5678);
      add("m_prid",     1, CP0_PRID,     32'hFFFF_FFFF, CP0_PRID,     32'h0000_4220);
      add("m_badvaddr", 1, CP0_BADVADDR, 32'hFFFF_FFFF, CP0_BADVADDR, 32'h0000_0000);
      add("m_unmapped", 1, {5'd5, 3'd0}, 32'hFFFF_FFFF, {5'd5, 3'd0}, 32'h0000_0000);
      add("m_config1",  0, 8'h0,         32'h0,         CP0_CONFIG1,  32'h0000_0000);
      add("m_wired",    1, CP0_WIRED,    32'hFFFF_FFF4, CP0_WIRED,    32'h0000_0004);
      run_vecs();

      // Interrupt lines land in Cause.IP[15:10] one cycle after they change.
      bus.interrupt = 6'h21;
      tick();
      rd("cause_ip_sample", CP0_CAUSE, 32'h0000_8700);
      bus.interrupt = 6'h00;
      tick();
      rd("cause_ip_clear", CP0_CAUSE, 32'h0000_0300);

      // Random with Wired=4: 15 down to 4, then reload.
      wr(CP0_WIRED, 32'd4);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("random_seq[%0d]", i), 32'(bus.random), 32'(15 - (i % 12)));
         tick();
      end
      wr(CP0_WIRED, 32'd15);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("random_pinned[%0d]", i), 32'(bus.random), 32'd15);
         tick();
      end
      wr(CP0_WIRED, 32'd0);

      // Count wrap and timer interrupt.
      wr(CP0_STATUS, 32'h0000_8001);
      wr(CP0_COMPARE, 32'hFFFF_FFFF);
      wr(CP0_COUNT, 32'hFFFF_FFFE);
      begin
         logic [31:0] cexp [5];
         cexp[0] = 32'hFFFF_FFFE; cexp[1] = 32'hFFFF_FFFE;
         cexp[2] = 32'hFFFF_FFFF; cexp[3] = 32'hFFFF_FFFF; cexp[4] = 32'h0000_0000;
         for (int i = 0; i < 5; i++) rd($sformatf("count_wrap[%0d]", i), CP0_COUNT, cexp[i]);
      end
      chk("timer_has_int", 32'(bus.has_int), 32'h1);
      rd("cause_ti_set", CP0_CAUSE, 32'h4000_8300);
      wr(CP0_COMPARE, 32'h1000_0000);
      rd("cause_ti_clr_ip_lag", CP0_CAUSE, 32'h0000_8300);
      rd("cause_ti_clr", CP0_CAUSE, 32'h0000_0300);
      chk("timer_int_gone", 32'(bus.has_int), 32'h0);

      // Exception capture, nested exception, ERET.
      set_exc(32'h8000_1000, EXC_TLBL, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
      tick();
      bus.exc_valid = 1'b0;
      chk("exc_epc", bus.epc, 32'h8000_1000);
      chk("exc_status", bus.status, 32'h0040_8003);
      chk("exc_no_int", 32'(bus.has_int), 32'h0);
      rd("exc_context", CP0_CONTEXT, 32'hFF89_1A20);
      rd("exc_badvaddr", CP0_BADVADDR, 32'h1234_5678);
      rd("exc_entryhi", CP0_ENTRYHI, 32'h1234_40FF);
      rd("exc_cause", CP0_CAUSE, 32'h8000_0308);
      set_exc(32'h8000_2000, EXC_ADEL, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      tick();
      bus.exc_valid = 1'b0;
      chk("nested_epc", bus.epc, 32'h8000_1000);
      rd("nested_cause", CP0_CAUSE, 32'h8000_0310);
      rd("nested_badvaddr", CP0_BADVADDR, 32'h1234_5678);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("eret_status", bus.status, 32'h0040_8001);

      // Same-cycle priority: exception beats ERET and software Status/EPC writes.
      set_exc(32'h8000_3000, EXC_INT, 1'b0, 1'b0, 1'b0, 32'h0);
      bus.eret = 1'b1;
      wr(CP0_STATUS, 32'h0000_8001);
      bus.exc_valid = 1'b0;
      bus.eret = 1'b0;
      chk("prio_exl", bus.status, 32'h0040_8003);
      chk("prio_epc1", bus.epc, 32'h8000_3000);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      set_exc(32'h8000_4000, EXC_SYS, 1'b0, 1'b0, 1'b0, 32'h0);
      wr(CP0_EPC, 32'hDEAD_BEEF);
      bus.exc_valid = 1'b0;
      chk("prio_epc2", bus.epc, 32'h8000_4000);
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;

      // TLBP miss then hit, TLBR masked load.
      bus.tlbp_ena = 1'b1; bus.tlbp_hit = 1'b0; bus.tlbp_idx = 4'd3;
      tick();
      bus.tlbp_ena = 1'b0;
      rd("tlbp_miss", CP0_INDEX, 32'h8000_000F);
      chk("tlbp_miss_out", 32'(bus.index), 32'h0000_000F);
      bus.tlbp_ena = 1'b1; bus.tlbp_hit = 1'b1; bus.tlbp_idx = 4'd7;
      tick();
      bus.tlbp_ena = 1'b0;
      rd("tlbp_hit", CP0_INDEX, 32'h0000_0007);
      chk("tlbp_hit_out", 32'(bus.index), 32'h0000_0007);
      bus.tlbr_ena = 1'b1;
      bus.tlbr_entryhi = 32'hABCD_EF12; bus.tlbr_entrylo0 = 32'hFC00_0001; bus.tlbr_entrylo1 = 32'h1234_5678;
      tick();
      bus.tlbr_ena = 1'b0;
      chk("tlbr_entryhi", bus.entryhi, 32'hABCD_E012);
      chk("tlbr_entrylo0", bus.entrylo0, 32'h0000_0001);
      chk("tlbr_entrylo1", bus.entrylo1, 32'h0234_5678);
      chk("config_k0", 32'(bus.config_k0), 32'd2);

      // Reset mid-operation wins over every other input.
      rst = 1'b1;
      set_exc(32'h8000_5000, EXC_OV, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      bus.tlbp_ena = 1'b1; bus.tlbp_hit = 1'b1;
      wr(CP0_STATUS, 32'hFFFF_FFFF);
      bus.exc_valid = 1'b0; bus.tlbp_ena = 1'b0;
      chk("mrst_status", bus.status, 32'h0040_0000);
      chk("mrst_epc", bus.epc, 32'h0);
      chk("mrst_index", 32'(bus.index), 32'h0);
      chk("mrst_random", 32'(bus.random), 32'd15);
      chk("mrst_entryhi", bus.entryhi, 32'h0);
      chk("mrst_k0", 32'(bus.config_k0), 32'd3);
      chk("mrst_has_int", 32'(bus.has_int), 32'h0);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
